// File: rtl/mega_logic_unit_if.sv
// Operand/result handshake bundle for mega_logic_unit: an operand channel from
// the source and a result channel to the consumer, each with valid/ready.
interface mega_logic_unit_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             chain;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             zero;
  logic             ones;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid, a, b, op, chain, out_ready,
    input  in_ready, out_valid, r, zero, ones, count
  );

  modport slave (
    input  in_valid, a, b, op, chain, out_ready,
    output in_ready, out_valid, r, zero, ones, count
  );
endinterface

// File: rtl/mega_logic_unit.sv
// Registered WIDTH-bit bitwise logic unit with a chaining accumulator and a
// one-entry valid/ready result stage; one result per accepted operand pair.
module mega_logic_unit #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mega_logic_unit_if.slave bus
);

  function automatic logic [WIDTH-1:0] f_logic_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] res;
    case (op)
      3'b000:  res = x & y;
      3'b001:  res = x | y;
      3'b010:  res = x ^ y;
      3'b011:  res = ~(x & y);
      3'b100:  res = ~(x | y);
      3'b101:  res = ~(x ^ y);
      3'b110:  res = x & ~y;
      default: res = y;
    endcase
    return res;
  endfunction

  logic             r_out_valid;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_acc;
  logic             r_zero;
  logic             r_ones;
  logic [CNT_W-1:0] r_count;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] w_res;

  // Chaining folds the previous result in as X and moves A into the Y slot.
  assign w_x        = bus.chain ? r_acc : bus.a;
  assign w_y        = bus.chain ? bus.a : bus.b;
  assign w_res      = f_logic_op(bus.op, w_x, w_y);
  assign w_in_ready = ~r_out_valid | bus.out_ready;
  assign w_accept   = bus.in_valid & w_in_ready;

  // Result stage: reload on accept, otherwise drain when the consumer takes R.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_r         <= '0;
      r_acc       <= '0;
      r_zero      <= 1'b1;
      r_ones      <= 1'b0;
      r_count     <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_r         <= w_res;
      r_acc       <= w_res;
      r_zero      <= (w_res == '0);
      r_ones      <= (w_res == '1);
      r_count     <= r_count + CNT_W'(1);
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.r         = r_r;
  assign bus.zero      = r_zero;
  assign bus.ones      = r_ones;
  assign bus.count     = r_count;

endmodule

// File: tb/tb_mega_logic_unit.sv
// Scoreboard bench for mega_logic_unit: a 64-bit instance exercised through
// op, chain, backpressure and reset scenarios, plus an 8-bit/4-bit-count one.
module tb_mega_logic_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mega_logic_unit_if #(.WIDTH(64), .CNT_W(16)) bus ();
  mega_logic_unit_if #(.WIDTH(8),  .CNT_W(4))  bus8 ();

  mega_logic_unit #(.WIDTH(64), .CNT_W(16)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  mega_logic_unit #(.WIDTH(8), .CNT_W(4)) u_dut8 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus8)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] q[$];
  logic        m_ov  = 1'b0;
  logic [63:0] m_acc = '0;
  logic [15:0] m_cnt = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mdl(input logic [2:0] op, input logic [63:0] x,
                                      input logic [63:0] y);
    case (op)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x & y);
      3'd4: return ~(x | y);
      3'd5: return ~(x ^ y);
      3'd6: return x & ~y;
      default: return y;
    endcase
  endfunction

  // One clock of stimulus: check state, drive inputs, update the model.
  task automatic step(input bit rs, input bit iv, input logic [63:0] a,
                      input logic [63:0] b, input logic [2:0] op, input bit ch,
                      input bit ordy);
    logic [63:0] e;
    logic [63:0] x;
    logic [63:0] y;
    @(negedge clk);
    chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
    chk("count", 64'(bus.count), 64'(m_cnt));
    rst           = rs;
    bus.in_valid  = iv;
    bus.a         = a;
    bus.b         = b;
    bus.op        = op;
    bus.chain     = ch;
    bus.out_ready = ordy;
    #1;
    if (rs) begin
      q.delete();
      m_ov  = 1'b0;
      m_acc = '0;
      m_cnt = '0;
    end else begin
      chk("in_ready", 64'(bus.in_ready), 64'(!m_ov || ordy));
      if (m_ov && ordy) begin
        if (q.size() == 0) begin
          chk("sb_empty", 64'(q.size()), 64'd1);
        end else begin
          e = q.pop_front();
          chk("r", bus.r, e);
          chk("zero", 64'(bus.zero), 64'(e == 64'd0));
          chk("ones", 64'(bus.ones), 64'(e == '1));
        end
      end
      if (iv && (!m_ov || ordy)) begin
        x = ch ? m_acc : a;
        y = ch ? a : b;
        e = mdl(op, x, y);
        q.push_back(e);
        m_acc = e;
        m_cnt = m_cnt + 16'd1;
        m_ov  = 1'b1;
      end else if (ordy) begin
        m_ov = 1'b0;
      end
    end
  endtask

  task automatic peek(input string tag, input logic [63:0] exp);
    @(posedge clk);
    #1;
    chk(tag, bus.r, exp);
  endtask

  task automatic check_reset();
    @(posedge clk);
    #1;
    chk("rst_r", bus.r, 64'd0);
    chk("rst_zero", 64'(bus.zero), 64'd1);
    chk("rst_ones", 64'(bus.ones), 64'd0);
    chk("rst_ov", 64'(bus.out_valid), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.chain = 1'b0;
    bus.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.op = '0; bus8.chain = 1'b0;
    bus8.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    check_reset();

    // Basic AND
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hAAAA_AAAA_AAAA_AAAA, 3'd0, 0, 1);
    @(posedge clk);
    #1;
    chk("and_r", bus.r, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("and_ov", 64'(bus.out_valid), 64'd1);
    chk("and_zero", 64'(bus.zero), 64'd0);
    chk("and_ones", 64'(bus.ones), 64'd0);
    chk("and_count", 64'(bus.count), 64'd1);

    // Op sweep from a fresh reset
    step(1, 0, '0, '0, 3'd0, 0, 1);
    for (int i = 0; i < 8; i++)
      step(0, 1, 64'h0F0F_0000_FFFF_1234, 64'h00FF_FFFF_0000_4321, 3'(i), 0, 1);
    @(posedge clk);
    #1;
    chk("sweep_count", 64'(bus.count), 64'd8);
    chk("sweep_last", bus.r, 64'h00FF_FFFF_0000_4321);

    // Chain fold
    step(0, 1, 64'h0, 64'h00FF, 3'd7, 0, 1);
    peek("fold0", 64'h00FF);
    step(0, 1, 64'hFF00, 64'h0, 3'd1, 1, 1);
    peek("fold1", 64'hFFFF);
    step(0, 1, 64'h0F0F, 64'h0, 3'd2, 1, 1);
    peek("fold2", 64'hF0F0);
    step(0, 1, 64'h0, 64'h0, 3'd0, 1, 1);
    peek("fold3", 64'h0);
    chk("fold3_zero", 64'(bus.zero), 64'd1);

    // Backpressure
    step(1, 0, '0, '0, 3'd0, 0, 1);
    step(0, 1, 64'h0, 64'h1111, 3'd7, 0, 1);
    peek("bp_first", 64'h1111);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 64'(100 + i), 64'h2222, 3'd1, 0, 0);
      chk("bp_frozen", bus.r, 64'h1111);
    end
    @(posedge clk);
    #1;
    chk("bp_count", 64'(bus.count), 64'd1);
    step(0, 1, 64'h0, 64'h3333, 3'd7, 0, 1);
    peek("bp_release", 64'h3333);

    // Reset mid-operation
    step(0, 1, 64'h0, 64'h4444, 3'd7, 0, 0);
    step(1, 1, 64'h0, 64'h5555, 3'd7, 0, 0);
    check_reset();
    step(0, 1, 64'h5, 64'h0, 3'd1, 1, 1);
    peek("post_rst_chain", 64'h5);
    step(0, 0, '0, '0, 3'd0, 0, 1);
    step(0, 0, '0, '0, 3'd0, 0, 1);

    // Narrow build: count wrap at 4 bits
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bus8.in_valid = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.op = 3'd0;
      bus8.chain = 1'b0; bus8.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("w8_count", 64'(bus8.count), 64'((i + 1) % 16));
    end
    chk("w8_r", 64'(bus8.r), 64'hFF);
    chk("w8_ones", 64'(bus8.ones), 64'd1);
    chk("w8_zero", 64'(bus8.zero), 64'd0);
    @(negedge clk);
    bus8.in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mega_logic_unit.md
# mega_logic_unit

Parametrised, registered successor to the 64-bit combinational AND block: a WIDTH-bit bitwise logic unit with eight selectable operations, a chaining accumulator for folding a stream of operands, and a one-entry valid/ready output stage. It sits between an operand source and a consumer that may apply backpressure. It produces one registered result per accepted operand pair.

## Interface
- WIDTH, 64, operand/result width in bits (≥1)
- CNT_W, 16, width of the accepted-transaction counter
- CLK  in  1  rising-edge clock, single clock domain
- RST  in  1  synchronous, active-high reset
- IN_VALID  in  1  operand pair presented
- IN_READY  out  1  unit can accept this cycle
- A  in  WIDTH  first operand
- B  in  WIDTH  second operand (ignored when CHAIN=1)
- OP  in  3  operation select, sampled with A/B
- CHAIN  in  1  0: result = A op B; 1: result = ACC op A
- OUT_VALID  out  1  R holds an unconsumed result
- OUT_READY  in  1  consumer takes R this cycle
- R  out  WIDTH  registered result
- ZERO  out  1  registered: R == 0
- ONES  out  1  registered: R == all ones
- COUNT  out  CNT_W  number of accepted operand pairs, mod 2^CNT_W

## Operation
- OP encoding (X = A when CHAIN=0, ACC when CHAIN=1; Y = B when CHAIN=0, A when CHAIN=1):
  - 000 X&Y
  - 001 X|Y
  - 010 X^Y
  - 011 ~(X&Y)
  - 100 ~(X|Y)
  - 101 ~(X^Y)
  - 110 X&~Y
  - 111 Y (load)
- All operations are purely bitwise, WIDTH bits wide, with no carries or sign handling.
- Accept = IN_VALID & IN_READY at a rising CLK edge. On accept:
  - R ← result
  - ACC ← result
  - ZERO/ONES update from result
  - OUT_VALID ← 1
  - COUNT ← COUNT+1
- ACC is internal and not a port. It always holds the most recently accepted result, so a CHAIN=0 accept starts a new fold.
- IN_READY = ~OUT_VALID | OUT_READY. It is combinational, with no dependency on IN_VALID.
- OUT_READY & OUT_VALID with no accept: OUT_VALID ← 0. R, ZERO, ONES and ACC hold their values.
- Consume and accept on the same edge: OUT_VALID stays 1 and R takes the new result, so full throughput is 1 result/cycle.
- OUT_VALID=1 & OUT_READY=0: the unit stalls. R, ACC and COUNT are frozen, and IN_VALID/A/B/OP/CHAIN are ignored.
- COUNT wraps from all-ones to 0 silently.
- CHAIN=1 immediately after reset uses ACC=0.

## Timing
- Latency is 1 cycle: R is valid at the edge following accept.
- Reset values (RST high at an edge; RST has priority over everything):
  - OUT_VALID=0
  - R=0
  - ACC=0
  - ZERO=1
  - ONES=0
  - COUNT=0
- IN_READY=1 during reset and on the first cycle after reset.
- Reset mid-operation: any pending, unconsumed result is discarded with no output handshake. An IN_VALID asserted in the same cycle as RST is not accepted and COUNT does not increment.
- R, ZERO and ONES are stable whenever OUT_VALID=1 and OUT_READY=0.
- There are no combinational paths from A/B/OP/CHAIN to any output. The only combinational path is OUT_READY→IN_READY.

## Test plan
- **Basic AND.** After reset, accept A=64'hFFFF_FFFF_FFFF_FFFF, B=64'hAAAA_AAAA_AAAA_AAAA, OP=000, CHAIN=0 with OUT_READY=1. Required response:
  - next cycle: R=64'hAAAA_AAAA_AAAA_AAAA, OUT_VALID=1, ZERO=0, ONES=0
  - COUNT=1
- **Op sweep.** With A=64'h0F0F_0000_FFFF_1234 and B=64'h00FF_FFFF_0000_4321, drive OP=0..7 back-to-back. Required response:
  - R matches the bitwise model for each op on consecutive cycles
  - OUT_VALID stays 1 throughout
  - COUNT=8
- **Chain fold.** Sequence:
  - OP=111 CHAIN=0 B=64'h00FF
  - then OP=001 CHAIN=1 A=64'hFF00
  - then OP=010 CHAIN=1 A=64'h0F0F

  Required R sequence: 64'h00FF, 64'hFFFF, 64'hF0F0. Then accept OP=000 CHAIN=1 A=0, which requires R=0 and ZERO=1.
- **Backpressure.** Accept one pair, then hold OUT_READY=0 for 5 cycles while IN_VALID=1 with changing A. Required response:
  - IN_READY=0
  - R frozen at the first result
  - COUNT=1

  Raise OUT_READY: the second operand is accepted on that edge and R updates the next cycle.
- **Reset mid-operation.** With OUT_VALID=1 and OUT_READY=0, assert RST for 1 cycle together with IN_VALID=1. Required response after the edge:
  - OUT_VALID=0, R=0, ZERO=1, COUNT=0
  - a following CHAIN=1 OP=001 A=5 gives R=5
- **Wrap and width.** Build with WIDTH=8 and CNT_W=4, then accept 17 pairs with A=8'hFF, B=8'hFF, OP=000. Required response:
  - COUNT=1 after the 17th accept
  - R=8'hFF, ONES=1, ZERO=0
